// File: rtl/ex_mem_skid_reg.sv
// EX/MEM pipeline register with valid/ready handshake, 2-entry skid buffer and flush.
// Define EX_MEM_STATS_EN to add saturating stall/flush statistics counters.
module ex_mem_skid_reg #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int SIDE_W = 4,
   parameter int STAT_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_EX,
   output logic              ready_EX,
   input  logic [DATA_W-1:0] aluRes_EX,
   input  logic [DATA_W-1:0] writeData_EX,
   input  logic [REG_W-1:0]  writeReg_EX,
   input  logic              memToReg_EX,
   input  logic              memWrite_EX,
   input  logic              regWrite_EX,
   input  logic [SIDE_W-1:0] side_EX,
   input  logic              flush,
   output logic              valid_MEM,
   input  logic              ready_MEM,
   output logic [DATA_W-1:0] aluRes_MEM,
   output logic [DATA_W-1:0] writeData_MEM,
   output logic [REG_W-1:0]  writeReg_MEM,
   output logic [SIDE_W-1:0] side_MEM,
   output logic              memToReg_MEM,
   output logic              memWrite_MEM,
   output logic              regWrite_MEM
`ifdef EX_MEM_STATS_EN
   ,
   output logic [STAT_W-1:0] stallCnt,
   output logic [STAT_W-1:0] flushCnt
`endif
);

   localparam int PAY_W = 2*DATA_W + REG_W + SIDE_W + 3;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [PAY_W-1:0] r_head;
   logic [PAY_W-1:0] r_skid;
   logic [PAY_W-1:0] w_in_pay;
   logic             w_vh;
   logic             w_vs;
   logic             w_acc;
   logic             w_con;
   logic             w_load_h;
   logic             w_load_s;
   logic             w_h_from_s;
   logic             w_m2r;
   logic             w_mw;
   logic             w_rw;

   assign w_in_pay = {aluRes_EX, writeData_EX, writeReg_EX, side_EX,
                      memToReg_EX, memWrite_EX, regWrite_EX};
   assign w_vh     = (r_state != ST_EMPTY);
   assign w_vs     = (r_state == ST_TWO);
   // ready depends only on the skid valid bit, never on ready_MEM
   assign ready_EX = ~w_vs & ~rst;
   assign w_acc    = valid_EX & ready_EX;
   assign w_con    = w_vh & ready_MEM;

   always_comb begin
      w_state_nxt = r_state;
      w_load_h    = 1'b0;
      w_load_s    = 1'b0;
      w_h_from_s  = 1'b0;
      case (r_state)
         ST_EMPTY: begin
            if (w_acc) begin
               w_state_nxt = ST_ONE;
               w_load_h    = 1'b1;
            end
         end
         ST_ONE: begin
            if (w_acc && w_con) begin
               w_load_h    = 1'b1;
            end else if (w_acc) begin
               w_state_nxt = ST_TWO;
               w_load_s    = 1'b1;
            end else if (w_con) begin
               w_state_nxt = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (w_con) begin
               w_state_nxt = ST_ONE;
               w_h_from_s  = 1'b1;
            end
         end
         default: w_state_nxt = ST_EMPTY;
      endcase
      if (flush) begin
         w_state_nxt = ST_EMPTY;
         w_load_h    = 1'b0;
         w_load_s    = 1'b0;
         w_h_from_s  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_head <= '0;
         r_skid <= '0;
      end else begin
         if (w_load_h) begin
            r_head <= w_in_pay;
         end else if (w_h_from_s) begin
            r_head <= r_skid;
         end
         if (w_load_s) begin
            r_skid <= w_in_pay;
         end
      end
   end

   assign {aluRes_MEM, writeData_MEM, writeReg_MEM, side_MEM, w_m2r, w_mw, w_rw} = r_head;
   assign valid_MEM    = w_vh;
   // bubbles must never write memory or the register file
   assign memToReg_MEM = w_m2r & w_vh;
   assign memWrite_MEM = w_mw  & w_vh;
   assign regWrite_MEM = w_rw  & w_vh;

`ifdef EX_MEM_STATS_EN
   localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

   logic [STAT_W-1:0] r_stall_cnt;
   logic [STAT_W-1:0] r_flush_cnt;
   logic [1:0]        w_held;
   logic [STAT_W:0]   w_flush_sum;

   // vS implies vH, so the held count is 2 in TWO and 1 in ONE
   assign w_held      = {w_vs, w_vh & ~w_vs};
   assign w_flush_sum = {1'b0, r_flush_cnt} + {{(STAT_W-1){1'b0}}, w_held};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= {STAT_W{1'b0}};
         r_flush_cnt <= {STAT_W{1'b0}};
      end else begin
         if (w_vh && !ready_MEM && (r_stall_cnt != STAT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + {{(STAT_W-1){1'b0}}, 1'b1};
         end
         if (flush) begin
            r_flush_cnt <= (w_flush_sum > {1'b0, STAT_MAX}) ? STAT_MAX : w_flush_sum[STAT_W-1:0];
         end
      end
   end

   assign stallCnt = r_stall_cnt;
   assign flushCnt = r_flush_cnt;
`else
   logic [STAT_W-1:0] w_stats_unused;
   assign w_stats_unused = {STAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Self-checking bench for ex_mem_skid_reg: directed scenarios plus random traffic
// compared against a FIFO-of-depth-2 reference model.
module tb_ex_mem_skid_reg;

   typedef struct packed {
      logic [31:0] alu;
      logic [31:0] wd;
      logic [4:0]  wr;
      logic [3:0]  side;
      logic        m2r;
      logic        mw;
      logic        rw;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst, valid_EX, ready_EX, flush, valid_MEM, ready_MEM;
   logic [31:0] aluRes_EX, writeData_EX, aluRes_MEM, writeData_MEM;
   logic [4:0]  writeReg_EX, writeReg_MEM;
   logic [3:0]  side_EX, side_MEM;
   logic        memToReg_EX, memWrite_EX, regWrite_EX;
   logic        memToReg_MEM, memWrite_MEM, regWrite_MEM;
`ifdef EX_MEM_STATS_EN
   logic [3:0]  stallCnt, flushCnt;
`endif

   int   n_tests = 0;
   int   n_fail  = 0;
   ent_t q[$];
   logic [31:0] seen[$];
   int   stall_exp = 0;
   int   flush_exp = 0;

   always #5 clk = ~clk;

   ex_mem_skid_reg #(.DATA_W(32), .REG_W(5), .SIDE_W(4), .STAT_W(4)) dut (
      .clk(clk), .rst(rst), .valid_EX(valid_EX), .ready_EX(ready_EX),
      .aluRes_EX(aluRes_EX), .writeData_EX(writeData_EX), .writeReg_EX(writeReg_EX),
      .memToReg_EX(memToReg_EX), .memWrite_EX(memWrite_EX), .regWrite_EX(regWrite_EX),
      .side_EX(side_EX), .flush(flush), .valid_MEM(valid_MEM), .ready_MEM(ready_MEM),
      .aluRes_MEM(aluRes_MEM), .writeData_MEM(writeData_MEM), .writeReg_MEM(writeReg_MEM),
      .side_MEM(side_MEM), .memToReg_MEM(memToReg_MEM), .memWrite_MEM(memWrite_MEM),
      .regWrite_MEM(regWrite_MEM)
`ifdef EX_MEM_STATS_EN
      , .stallCnt(stallCnt), .flushCnt(flushCnt)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input bit v, input logic [31:0] a);
      valid_EX     = v;
      aluRes_EX    = a;
      writeData_EX = ~a;
      writeReg_EX  = a[4:0];
      side_EX      = a[7:4];
      memToReg_EX  = a[0];
      memWrite_EX  = a[1];
      regWrite_EX  = 1'b1;
   endtask

   function automatic ent_t cur_in();
      ent_t e;
      e.alu  = aluRes_EX;
      e.wd   = writeData_EX;
      e.wr   = writeReg_EX;
      e.side = side_EX;
      e.m2r  = memToReg_EX;
      e.mw   = memWrite_EX;
      e.rw   = regWrite_EX;
      return e;
   endfunction

   task automatic check_out();
      chk("valid_MEM", valid_MEM, q.size() > 0);
      chk("ready_EX", ready_EX, !rst && q.size() < 2);
      if (q.size() > 0) begin
         chk("aluRes_MEM", aluRes_MEM, q[0].alu);
         chk("writeData_MEM", writeData_MEM, q[0].wd);
         chk("writeReg_MEM", writeReg_MEM, q[0].wr);
         chk("side_MEM", side_MEM, q[0].side);
         chk("memToReg_MEM", memToReg_MEM, q[0].m2r);
         chk("memWrite_MEM", memWrite_MEM, q[0].mw);
         chk("regWrite_MEM", regWrite_MEM, q[0].rw);
      end else begin
         chk("ctrl_gated", {memToReg_MEM, memWrite_MEM, regWrite_MEM}, 3'b000);
      end
`ifdef EX_MEM_STATS_EN
      chk("stallCnt", stallCnt, stall_exp);
      chk("flushCnt", flushCnt, flush_exp);
`endif
   endtask

   // One clock of the reference model: a FIFO of depth 2 with flush and reset.
   task automatic cycle();
      bit   acc, con;
      ent_t e;
      int   held;
      acc  = valid_EX && !rst && q.size() < 2;
      con  = q.size() > 0 && ready_MEM;
      e    = cur_in();
      held = q.size();
      @(posedge clk);
      if (rst) begin
         q.delete();
         stall_exp = 0;
         flush_exp = 0;
      end else begin
         if (held > 0 && !ready_MEM) stall_exp = (stall_exp >= 15) ? 15 : stall_exp + 1;
         if (flush) begin
            flush_exp = (flush_exp + held > 15) ? 15 : flush_exp + held;
            q.delete();
         end else begin
            if (con) begin
               seen.push_back(q[0].alu);
               void'(q.pop_front());
            end
            if (acc) q.push_back(e);
         end
      end
      @(negedge clk);
      check_out();
   endtask

   initial begin
      int hits;
      rst = 1'b1; flush = 1'b0; ready_MEM = 1'b0;
      set_in(1'b0, 32'h0);
      cycle();
      cycle();
      chk("rst_aluRes", aluRes_MEM, 32'h0);
      rst = 1'b0;
      cycle();

      // reset while stalled in TWO
      set_in(1'b1, 32'h0000_00A3); cycle();
      set_in(1'b1, 32'h0000_00B3); cycle();
      chk("two_ready_low", ready_EX, 1'b0);
      set_in(1'b0, 32'h0); rst = 1'b1; cycle();
      chk("rst_two_aluRes", aluRes_MEM, 32'h0);
      chk("rst_two_regWrite", regWrite_MEM, 1'b0);
      rst = 1'b0; cycle();
      chk("rst_release_ready", ready_EX, 1'b1);

      // stream of 8 back-to-back entries
      ready_MEM = 1'b1;
      seen.delete();
      for (int i = 1; i <= 8; i++) begin
         set_in(1'b1, 32'(i));
         cycle();
      end
      set_in(1'b0, 32'h0);
      cycle();
      chk("stream_count", seen.size(), 8);
      for (int i = 0; i < seen.size(); i++) chk("stream_order", seen[i], 32'(i + 1));

      // back-pressure into TWO then drain
      ready_MEM = 1'b0;
      set_in(1'b1, 32'h10); cycle();
      set_in(1'b1, 32'h20); cycle();
      chk("bp_ready_low", ready_EX, 1'b0);
      set_in(1'b0, 32'h0); ready_MEM = 1'b1;
      cycle(); cycle();
      chk("bp_first", seen[seen.size()-2], 32'h10);
      chk("bp_second", seen[seen.size()-1], 32'h20);
      chk("bp_count", seen.size(), 10);

      // flush in TWO while EX presents C
      ready_MEM = 1'b0;
      set_in(1'b1, 32'h42); cycle();
      set_in(1'b1, 32'h52); cycle();
      set_in(1'b1, 32'h30); flush = 1'b1; cycle();
      chk("flush_valid", valid_MEM, 1'b0);
      chk("flush_memWrite", memWrite_MEM, 1'b0);
`ifdef EX_MEM_STATS_EN
      chk("flush_cnt2", flushCnt, 4'd2);
`endif
      flush = 1'b0; set_in(1'b0, 32'h0); ready_MEM = 1'b1;
      cycle(); cycle();
      hits = 0;
      foreach (seen[i]) if (seen[i] == 32'h30) hits++;
      chk("flush_no_C", hits, 0);

      // bubble with write-enables asserted
      valid_EX = 1'b0; memWrite_EX = 1'b1; regWrite_EX = 1'b1;
      cycle();
      chk("bubble_memWrite", memWrite_MEM, 1'b0);
      chk("bubble_regWrite", regWrite_MEM, 1'b0);

      // long stall saturates the stall counter
      rst = 1'b1; cycle(); rst = 1'b0;
      ready_MEM = 1'b0;
      set_in(1'b1, 32'h77); cycle();
      set_in(1'b0, 32'h0);
      for (int i = 0; i < 20; i++) cycle();
`ifdef EX_MEM_STATS_EN
      chk("stall_sat", stallCnt, 4'd15);
`endif
      chk("stall_hold", aluRes_MEM, 32'h77);
      ready_MEM = 1'b1; cycle();

      // random traffic
      for (int i = 0; i < 400; i++) begin
         valid_EX     = 1'($urandom);
         ready_MEM    = ($urandom_range(0, 3) != 0);
         flush        = ($urandom_range(0, 15) == 0);
         rst          = ($urandom_range(0, 63) == 0);
         aluRes_EX    = $urandom;
         writeData_EX = $urandom;
         writeReg_EX  = 5'($urandom);
         side_EX      = 4'($urandom);
         memToReg_EX  = 1'($urandom);
         memWrite_EX  = 1'($urandom);
         regWrite_EX  = 1'($urandom);
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
